// File: rtl/ysyx_22041071_axi_rd_arb_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_22041071_axi_rd_arb_pkg
// Shared constants for the two-port AXI read arbiter: requester IDs (also
// used as the internal owner encoding), FSM state encoding and the AXI
// width defaults of the surrounding core.
// ---------------------------------------------------------------------------
package ysyx_22041071_axi_rd_arb_pkg;

  // Requester IDs; the 1-bit owner register uses the same values
  localparam logic ARB_ID_IF  = 1'b0;
  localparam logic ARB_ID_MEM = 1'b1;

  // AXI field widths of the core
  localparam int AXI_LEN_WIDTH  = 8;
  localparam int AXI_ID_WIDTH   = 4;
  localparam int AXI_DATA_WIDTH = 64;
  localparam int AXI_ADDR_WIDTH = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DATA  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/ysyx_22041071_axi_rd_arb_pick.sv
// ---------------------------------------------------------------------------
// ysyx_22041071_arb_pick
// Combinational 2-way winner select.
// Ports:
//   if_valid_i   - IF request pending
//   mem_valid_i  - MEM request pending
//   last_grant_i - owner of the previous burst (IF=0, MEM=1)
//   rr_mode_i    - 1: round-robin on ties, 0: MEM wins ties
//   grant_o      - one-hot grant, bit0 = IF, bit1 = MEM
// ---------------------------------------------------------------------------
module ysyx_22041071_arb_pick
  import ysyx_22041071_axi_rd_arb_pkg::*;
(
  input  logic       if_valid_i,
  input  logic       mem_valid_i,
  input  logic       last_grant_i,
  input  logic       rr_mode_i,
  output logic [1:0] grant_o
);

  always_comb begin
    grant_o = 2'b00;
    if (if_valid_i && mem_valid_i) begin
      // round-robin favours whoever did not own the previous burst
      if (rr_mode_i && (last_grant_i == ARB_ID_MEM)) grant_o = 2'b01;
      else                                           grant_o = 2'b10;
    end else if (if_valid_i) begin
      grant_o = 2'b01;
    end else if (mem_valid_i) begin
      grant_o = 2'b10;
    end
  end

endmodule

// File: rtl/ysyx_22041071_axi_rd_arb.sv
// ---------------------------------------------------------------------------
// ysyx_22041071_axi_rd_arb
// Shares one AXI read engine between instruction fetch (IF) and data load
// (MEM). One requester is granted at a time; the grant is held for the whole
// burst, returned beats are counted against the requested length and routed
// back to the owner with a generated last flag.
//
// Build option: YSYX_22041071_ARB_RR_EN defined -> round-robin on ties
// (IF wins the first tie after reset); undefined -> MEM always wins ties.
//
// Ports:
//   clk, reset              - clock, synchronous active-high reset
//   if_req_* / mem_req_*    - request (valid/ready/addr/len/size)
//   if_rsp_* / mem_rsp_*    - registered beat return (valid/data/resp/last)
//   rd_ar_valid/rd_ar_ready - request handshake to the read engine
//   rd_id/addr/len/size     - latched request fields
//   rd_r_valid/data/resp    - beats returned by the read engine
// ---------------------------------------------------------------------------
module ysyx_22041071_axi_rd_arb
  import ysyx_22041071_axi_rd_arb_pkg::*;
#(
  parameter int ADDR_W = AXI_ADDR_WIDTH,
  parameter int DATA_W = AXI_DATA_WIDTH,
  parameter int LEN_W  = AXI_LEN_WIDTH,
  parameter int ID_W   = AXI_ID_WIDTH
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [ADDR_W-1:0] if_req_addr,
  input  logic [LEN_W-1:0]  if_req_len,
  input  logic [1:0]        if_req_size,

  input  logic              mem_req_valid,
  output logic              mem_req_ready,
  input  logic [ADDR_W-1:0] mem_req_addr,
  input  logic [LEN_W-1:0]  mem_req_len,
  input  logic [1:0]        mem_req_size,

  output logic              if_rsp_valid,
  output logic [DATA_W-1:0] if_rsp_data,
  output logic [1:0]        if_rsp_resp,
  output logic              if_rsp_last,

  output logic              mem_rsp_valid,
  output logic [DATA_W-1:0] mem_rsp_data,
  output logic [1:0]        mem_rsp_resp,
  output logic              mem_rsp_last,

  output logic              rd_ar_valid,
  input  logic              rd_ar_ready,
  output logic [ID_W-1:0]   rd_id,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [LEN_W-1:0]  rd_len,
  output logic [1:0]        rd_size,

  input  logic              rd_r_valid,
  input  logic [DATA_W-1:0] rd_r_data,
  input  logic [1:0]        rd_r_resp
);

  arb_state_e        state_q;
  logic              owner_q;
  logic [LEN_W-1:0]  cnt_q;
  logic              rd_ar_valid_q;
  logic [ID_W-1:0]   rd_id_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [LEN_W-1:0]  rd_len_q;
  logic [1:0]        rd_size_q;

  logic              if_rsp_valid_q,  mem_rsp_valid_q;
  logic [DATA_W-1:0] if_rsp_data_q,   mem_rsp_data_q;
  logic [1:0]        if_rsp_resp_q,   mem_rsp_resp_q;
  logic              if_rsp_last_q,   mem_rsp_last_q;

  logic [1:0]        grant;
  logic              last_grant;
  logic              rr_mode;
  logic              sel_mem;
  logic              beat_last;

`ifdef YSYX_22041071_ARB_RR_EN
  logic last_grant_q;
  assign last_grant = last_grant_q;
  assign rr_mode    = 1'b1;
`else
  assign last_grant = ARB_ID_MEM;
  assign rr_mode    = 1'b0;
`endif

  ysyx_22041071_arb_pick u_pick (
    .if_valid_i   (if_req_valid),
    .mem_valid_i  (mem_req_valid),
    .last_grant_i (last_grant),
    .rr_mode_i    (rr_mode),
    .grant_o      (grant)
  );

  // ready is only offered while idle; the pick output is purely from valid
  assign if_req_ready  = (state_q == ST_IDLE) && grant[0];
  assign mem_req_ready = (state_q == ST_IDLE) && grant[1];
  assign sel_mem       = grant[1];
  assign beat_last     = (cnt_q == rd_len_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      owner_q         <= ARB_ID_IF;
      cnt_q           <= '0;
      rd_ar_valid_q   <= 1'b0;
      rd_id_q         <= '0;
      rd_addr_q       <= '0;
      rd_len_q        <= '0;
      rd_size_q       <= '0;
      if_rsp_valid_q  <= 1'b0;
      if_rsp_data_q   <= '0;
      if_rsp_resp_q   <= '0;
      if_rsp_last_q   <= 1'b0;
      mem_rsp_valid_q <= 1'b0;
      mem_rsp_data_q  <= '0;
      mem_rsp_resp_q  <= '0;
      mem_rsp_last_q  <= 1'b0;
`ifdef YSYX_22041071_ARB_RR_EN
      last_grant_q    <= ARB_ID_MEM;
`endif
    end else begin
      // response strobes are single-cycle pulses
      if_rsp_valid_q  <= 1'b0;
      if_rsp_last_q   <= 1'b0;
      mem_rsp_valid_q <= 1'b0;
      mem_rsp_last_q  <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (grant != 2'b00) begin
            owner_q       <= sel_mem;
            rd_id_q       <= sel_mem ? ID_W'(ARB_ID_MEM) : ID_W'(ARB_ID_IF);
            rd_addr_q     <= sel_mem ? mem_req_addr : if_req_addr;
            rd_len_q      <= sel_mem ? mem_req_len  : if_req_len;
            rd_size_q     <= sel_mem ? mem_req_size : if_req_size;
            cnt_q         <= '0;
            rd_ar_valid_q <= 1'b1;
            state_q       <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          if (rd_ar_ready) begin
            rd_ar_valid_q <= 1'b0;
            state_q       <= ST_DATA;
          end
        end

        ST_DATA: begin
          if (rd_r_valid) begin
            if (owner_q == ARB_ID_MEM) begin
              mem_rsp_valid_q <= 1'b1;
              mem_rsp_data_q  <= rd_r_data;
              mem_rsp_resp_q  <= rd_r_resp;
              mem_rsp_last_q  <= beat_last;
            end else begin
              if_rsp_valid_q  <= 1'b1;
              if_rsp_data_q   <= rd_r_data;
              if_rsp_resp_q   <= rd_r_resp;
              if_rsp_last_q   <= beat_last;
            end
            // wraps only on the final beat of a 256-beat burst, when it no
            // longer matters because the FSM leaves DATA
            cnt_q <= cnt_q + LEN_W'(1);
            if (beat_last) begin
              state_q <= ST_IDLE;
`ifdef YSYX_22041071_ARB_RR_EN
              last_grant_q <= owner_q;
`endif
            end
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rd_ar_valid   = rd_ar_valid_q;
  assign rd_id         = rd_id_q;
  assign rd_addr       = rd_addr_q;
  assign rd_len        = rd_len_q;
  assign rd_size       = rd_size_q;
  assign if_rsp_valid  = if_rsp_valid_q;
  assign if_rsp_data   = if_rsp_data_q;
  assign if_rsp_resp   = if_rsp_resp_q;
  assign if_rsp_last   = if_rsp_last_q;
  assign mem_rsp_valid = mem_rsp_valid_q;
  assign mem_rsp_data  = mem_rsp_data_q;
  assign mem_rsp_resp  = mem_rsp_resp_q;
  assign mem_rsp_last  = mem_rsp_last_q;

endmodule

// File: tb/tb_ysyx_22041071_axi_rd_arb.sv
// ---------------------------------------------------------------------------
// tb_ysyx_22041071_axi_rd_arb
// Directed bench for the two-port AXI read arbiter. Inputs are driven 1 time
// unit after the rising edge; outputs are checked 2 units after it.
// ---------------------------------------------------------------------------
module tb_ysyx_22041071_axi_rd_arb;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req_valid, mem_req_valid;
  logic        if_req_ready, mem_req_ready;
  logic [63:0] if_req_addr, mem_req_addr;
  logic [7:0]  if_req_len, mem_req_len;
  logic [1:0]  if_req_size, mem_req_size;
  logic        if_rsp_valid, mem_rsp_valid;
  logic [63:0] if_rsp_data, mem_rsp_data;
  logic [1:0]  if_rsp_resp, mem_rsp_resp;
  logic        if_rsp_last, mem_rsp_last;
  logic        rd_ar_valid, rd_ar_ready;
  logic [3:0]  rd_id;
  logic [63:0] rd_addr;
  logic [7:0]  rd_len;
  logic [1:0]  rd_size;
  logic        rd_r_valid;
  logic [63:0] rd_r_data;
  logic [1:0]  rd_r_resp;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ysyx_22041071_axi_rd_arb dut (
    .clk           (clk),
    .reset         (reset),
    .if_req_valid  (if_req_valid),
    .if_req_ready  (if_req_ready),
    .if_req_addr   (if_req_addr),
    .if_req_len    (if_req_len),
    .if_req_size   (if_req_size),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_req_len   (mem_req_len),
    .mem_req_size  (mem_req_size),
    .if_rsp_valid  (if_rsp_valid),
    .if_rsp_data   (if_rsp_data),
    .if_rsp_resp   (if_rsp_resp),
    .if_rsp_last   (if_rsp_last),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .mem_rsp_resp  (mem_rsp_resp),
    .mem_rsp_last  (mem_rsp_last),
    .rd_ar_valid   (rd_ar_valid),
    .rd_ar_ready   (rd_ar_ready),
    .rd_id         (rd_id),
    .rd_addr       (rd_addr),
    .rd_len        (rd_len),
    .rd_size       (rd_size),
    .rd_r_valid    (rd_r_valid),
    .rd_r_data     (rd_r_data),
    .rd_r_resp     (rd_r_resp)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // advance to the drive point of the next cycle
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // present one engine beat for exactly one edge; outputs are then checkable
  task automatic beat(input logic [63:0] data, input logic [1:0] resp);
    rd_r_valid = 1'b1;
    rd_r_data  = data;
    rd_r_resp  = resp;
    tick();
    rd_r_valid = 1'b0;
    #1;
  endtask

  // engine accepts the AR request on the next edge
  task automatic ar_accept();
    rd_ar_ready = 1'b1;
    tick();
    rd_ar_ready = 1'b0;
    #1;
  endtask

  logic exp_mem;

  initial begin
    reset = 1'b1;
    if_req_valid = 1'b0; if_req_addr = '0; if_req_len = '0; if_req_size = '0;
    mem_req_valid = 1'b0; mem_req_addr = '0; mem_req_len = '0; mem_req_size = '0;
    rd_ar_ready = 1'b0; rd_r_valid = 1'b0; rd_r_data = '0; rd_r_resp = '0;
    tick(); tick();
    reset = 1'b0;
    #1;

    // ---- reset values
    chk("rst_ar_valid", rd_ar_valid, 0);
    chk("rst_if_ready", if_req_ready, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_rd_id", rd_id, 0);
    chk("rst_if_rsp_valid", if_rsp_valid, 0);
    chk("rst_mem_rsp_valid", mem_rsp_valid, 0);

    // ---- IF-only single beat
    if_req_valid = 1'b1; if_req_addr = 64'h8000_0000; if_req_len = 8'd0; if_req_size = 2'b11;
    #1;
    chk("t1_if_ready", if_req_ready, 1);
    chk("t1_mem_ready", mem_req_ready, 0);
    tick();
    if_req_valid = 1'b0;
    #1;
    chk("t1_ar_valid", rd_ar_valid, 1);
    chk("t1_rd_id", rd_id, 0);
    chk("t1_rd_addr", rd_addr, 64'h8000_0000);
    chk("t1_rd_len", rd_len, 0);
    chk("t1_rd_size", rd_size, 3);
    ar_accept();
    chk("t1_ar_dropped", rd_ar_valid, 0);
    beat(64'hDEAD_BEEF_0000_0001, 2'b00);
    chk("t1_if_rsp_valid", if_rsp_valid, 1);
    chk("t1_if_rsp_last", if_rsp_last, 1);
    chk("t1_if_rsp_data", if_rsp_data, 64'hDEAD_BEEF_0000_0001);
    chk("t1_if_rsp_resp", if_rsp_resp, 0);
    chk("t1_mem_rsp_valid", mem_rsp_valid, 0);
    tick();
    chk("t1_if_rsp_pulse", if_rsp_valid, 0);

    // ---- MEM burst of 4
    mem_req_valid = 1'b1; mem_req_addr = 64'h1000; mem_req_len = 8'd3; mem_req_size = 2'b11;
    #1;
    chk("t2_mem_ready", mem_req_ready, 1);
    tick();
    mem_req_valid = 1'b0;
    #1;
    chk("t2_rd_id", rd_id, 1);
    chk("t2_rd_len", rd_len, 3);
    ar_accept();
    for (int i = 0; i < 4; i++) begin
      beat(64'h11 * (i + 1), 2'b00);
      chk("t2_mem_rsp_valid", mem_rsp_valid, 1);
      chk("t2_mem_rsp_data", mem_rsp_data, 64'h11 * (i + 1));
      chk("t2_mem_rsp_last", mem_rsp_last, (i == 3) ? 1 : 0);
      chk("t2_if_rsp_valid", if_rsp_valid, 0);
    end
    // IDLE right after the last beat: a new request is ready immediately
    if_req_valid = 1'b1;
    #1;
    chk("t2_idle_after_last", if_req_ready, 1);
    if_req_valid = 1'b0;
    tick();
    chk("t2_no_accept", rd_ar_valid, 0);

    // ---- tie for three grants (previous owner was MEM)
    if_req_addr = 64'h100; mem_req_addr = 64'h200; if_req_len = 8'd0; mem_req_len = 8'd0;
    if_req_valid = 1'b1; mem_req_valid = 1'b1;
    for (int g = 0; g < 3; g++) begin
`ifdef YSYX_22041071_ARB_RR_EN
      exp_mem = (g == 1);
`else
      exp_mem = 1'b1;
`endif
      #1;
      chk("t3_if_ready", if_req_ready, !exp_mem);
      chk("t3_mem_ready", mem_req_ready, exp_mem);
      tick();
      chk("t3_ready_in_issue", if_req_ready | mem_req_ready, 0);
      chk("t3_rd_id", rd_id, exp_mem);
      chk("t3_rd_addr", rd_addr, exp_mem ? 64'h200 : 64'h100);
      ar_accept();
      beat(64'hC0 + g, 2'b00);
      chk("t3_mem_rsp", mem_rsp_valid, exp_mem);
      chk("t3_if_rsp", if_rsp_valid, !exp_mem);
    end
    if_req_valid = 1'b0; mem_req_valid = 1'b0;
    tick();

    // ---- AR back-pressure for 5 cycles
    if_req_valid = 1'b1; if_req_addr = 64'h2000; if_req_len = 8'd2; if_req_size = 2'b10;
    tick();
    if_req_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("t4_ar_held", rd_ar_valid, 1);
      chk("t4_addr_held", rd_addr, 64'h2000);
      chk("t4_len_held", rd_len, 2);
    end
    ar_accept();
    chk("t4_ar_done", rd_ar_valid, 0);
    for (int i = 0; i < 3; i++) begin
      beat(64'h40 + i, 2'b00);
      chk("t4_if_rsp_valid", if_rsp_valid, 1);
      chk("t4_if_rsp_last", if_rsp_last, (i == 2) ? 1 : 0);
    end
    tick();

    // ---- stray beat in IDLE, then SLVERR mid-burst
    beat(64'hBAD, 2'b00);
    chk("t5_stray_if", if_rsp_valid, 0);
    chk("t5_stray_mem", mem_rsp_valid, 0);
    mem_req_valid = 1'b1; mem_req_addr = 64'h3000; mem_req_len = 8'd1;
    tick();
    mem_req_valid = 1'b0;
    ar_accept();
    beat(64'hA1, 2'b10);
    chk("t5_slverr_valid", mem_rsp_valid, 1);
    chk("t5_slverr_resp", mem_rsp_resp, 2);
    chk("t5_slverr_data", mem_rsp_data, 64'hA1);
    chk("t5_slverr_last", mem_rsp_last, 0);
    beat(64'hA2, 2'b00);
    chk("t5_end_valid", mem_rsp_valid, 1);
    chk("t5_end_last", mem_rsp_last, 1);
    chk("t5_end_resp", mem_rsp_resp, 0);

    // ---- 256-beat burst terminates exactly on beat 256
    mem_req_valid = 1'b1; mem_req_addr = 64'h4000; mem_req_len = 8'hFF;
    tick();
    mem_req_valid = 1'b0;
    ar_accept();
    for (int i = 0; i < 256; i++) begin
      beat(64'h5000 + i, 2'b00);
      chk("t6_long_valid", mem_rsp_valid, 1);
      chk("t6_long_last", mem_rsp_last, (i == 255) ? 1 : 0);
    end
    chk("t6_long_data", mem_rsp_data, 64'h50FF);
    tick();
    beat(64'h77, 2'b00);
    chk("t6_after_long_idle", mem_rsp_valid, 0);

    // ---- reset during beat 2 of a len-7 burst
    if_req_valid = 1'b1; if_req_addr = 64'h6000; if_req_len = 8'd7;
    tick();
    if_req_valid = 1'b0;
    ar_accept();
    beat(64'h61, 2'b00);
    chk("t7_beat1", if_rsp_valid, 1);
    reset = 1'b1;
    beat(64'h62, 2'b00);
    reset = 1'b0;
    chk("t7_rst_if_rsp", if_rsp_valid, 0);
    chk("t7_rst_data", if_rsp_data, 0);
    chk("t7_rst_ar", rd_ar_valid, 0);
    chk("t7_rst_addr", rd_addr, 0);
    chk("t7_rst_len", rd_len, 0);
    beat(64'h63, 2'b00);
    chk("t7_dropped", if_rsp_valid, 0);
    if_req_valid = 1'b1; if_req_addr = 64'h7000; if_req_len = 8'd0;
    #1;
    chk("t7_fresh_ready", if_req_ready, 1);
    tick();
    if_req_valid = 1'b0;
    #1;
    chk("t7_fresh_addr", rd_addr, 64'h7000);
    ar_accept();
    beat(64'h71, 2'b00);
    chk("t7_fresh_valid", if_rsp_valid, 1);
    chk("t7_fresh_last", if_rsp_last, 1);
    chk("t7_fresh_data", if_rsp_data, 64'h71);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
